ras_ctrl: RTL

Return-address-stack controller for the fetch stage. It decodes call/return hints from decoded jump instructions and manages a circular return-address stack of depth L_stack. It issues a registered return-target prediction on each return. It also saves and restores speculative stack state, so that a pipeline flush after a mispredict leaves the stack as it was at the checkpoint.

---
 rtl/ras_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ras_ctrl.sv
// Return-address stack controller: call/return decode, circular stack, registered prediction, checkpoint/restore.
// Optional per-event statistics counters are enabled with `define RAS_STATS_EN.
module ras_ctrl #(
    parameter  int W       = 32,
    parameter  int L_stack = 4,
    localparam int PTR_W   = $clog2(L_stack)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs,
    input  logic [W-1:0]     pc_plus4,
    input  logic             chk_save,
    input  logic             chk_restore,
    output logic             pred_valid,
    output logic [W-1:0]     pred_target,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
`ifdef RAS_STATS_EN
    ,
    output logic [15:0]      stat_push,
    output logic [15:0]      stat_pop,
    output logic [15:0]      stat_ovf,
    output logic [15:0]      stat_unf
`endif
);

    typedef enum logic [1:0] {ACT_NONE, ACT_PUSH, ACT_POP, ACT_POPPUSH} act_e;

    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(L_stack);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [W-1:0]     stack_q [L_stack];
    logic [W-1:0]     stack_d [L_stack];
    logic [PTR_W-1:0] tos_q, tos_d, tos_inc_s;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] snap_tos_q, snap_tos_d;
    logic [PTR_W:0]   snap_cnt_q, snap_cnt_d;
    logic [W-1:0]     snap_top_q, snap_top_d;
    logic             pv_q, pv_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [W-1:0]     pt_q, pt_d;
    logic             linkd_s, links_s;
    act_e             act_s;

    assign linkd_s   = (rd == 5'd1) || (rd == 5'd5);
    assign links_s   = is_jalr && ((rs == 5'd1) || (rs == 5'd5));
    assign tos_inc_s = tos_q + PTR_ONE;

    // Classify the decoded jump as push / pop / pop-then-push from link-register usage.
    always_comb begin
        act_s = ACT_NONE;
        if (in_valid && (is_jal ^ is_jalr)) begin
            if (is_jal) begin
                if (linkd_s) act_s = ACT_PUSH;
                else         act_s = ACT_NONE;
            end else if (linkd_s && !links_s) begin
                act_s = ACT_PUSH;
            end else if (!linkd_s && links_s) begin
                act_s = ACT_POP;
            end else if (linkd_s && links_s) begin
                act_s = (rd == rs) ? ACT_PUSH : ACT_POPPUSH;
            end else begin
                act_s = ACT_NONE;
            end
        end else begin
            act_s = ACT_NONE;
        end
    end

    // Next-state: restore overrides the action; a save captures the post-action state.
    always_comb begin
        stack_d    = stack_q;
        tos_d      = tos_q;
        count_d    = count_q;
        snap_tos_d = snap_tos_q;
        snap_cnt_d = snap_cnt_q;
        snap_top_d = snap_top_q;
        pv_d       = 1'b0;
        pt_d       = pt_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        if (chk_restore) begin
            tos_d               = snap_tos_q;
            count_d             = snap_cnt_q;
            stack_d[snap_tos_q] = snap_top_q;
        end else begin
            case (act_s)
                ACT_PUSH: begin
                    tos_d              = tos_inc_s;
                    stack_d[tos_inc_s] = pc_plus4;
                    if (count_q == CNT_FULL) ovf_d   = 1'b1;
                    else                     count_d = count_q + CNT_ONE;
                end
                ACT_POP: begin
                    if (count_q != CNT_ZERO) begin
                        pt_d    = stack_q[tos_q];
                        pv_d    = 1'b1;
                        tos_d   = tos_q - PTR_ONE;
                        count_d = count_q - CNT_ONE;
                    end else begin
                        unf_d   = 1'b1;
                    end
                end
                ACT_POPPUSH: begin
                    pt_d           = stack_q[tos_q];
                    pv_d           = (count_q != CNT_ZERO);
                    stack_d[tos_q] = pc_plus4;
                    if (count_q == CNT_ZERO) count_d = CNT_ONE;
                    else                     count_d = count_q;
                end
                default: begin
                    tos_d = tos_q;
                end
            endcase
            if (chk_save) begin
                snap_tos_d = tos_d;
                snap_cnt_d = count_d;
                snap_top_d = stack_d[tos_d];
            end else begin
                snap_tos_d = snap_tos_q;
            end
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L_stack; i++) stack_q[i] <= '0;
            tos_q      <= '0;
            count_q    <= '0;
            snap_tos_q <= '0;
            snap_cnt_q <= '0;
            snap_top_q <= '0;
            pv_q       <= 1'b0;
            pt_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            stack_q    <= stack_d;
            tos_q      <= tos_d;
            count_q    <= count_d;
            snap_tos_q <= snap_tos_d;
            snap_cnt_q <= snap_cnt_d;
            snap_top_q <= snap_top_d;
            pv_q       <= pv_d;
            pt_q       <= pt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign pred_valid  = pv_q;
    assign pred_target = pt_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

`ifdef RAS_STATS_EN
    logic [15:0] st_push_q, st_pop_q, st_ovf_q, st_unf_q;
    logic        ev_push_s, ev_pop_s;

    assign ev_push_s = !chk_restore && ((act_s == ACT_PUSH) || (act_s == ACT_POPPUSH));
    assign ev_pop_s  = !chk_restore && ((act_s == ACT_POP)  || (act_s == ACT_POPPUSH));

    // Saturating event counters; restore-cycle actions are discarded and not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_push_q <= 16'd0;
            st_pop_q  <= 16'd0;
            st_ovf_q  <= 16'd0;
            st_unf_q  <= 16'd0;
        end else begin
            if (ev_push_s && (st_push_q != 16'hFFFF)) st_push_q <= st_push_q + 16'd1;
            else                                      st_push_q <= st_push_q;
            if (ev_pop_s && (st_pop_q != 16'hFFFF))   st_pop_q  <= st_pop_q + 16'd1;
            else                                      st_pop_q  <= st_pop_q;
            if (ovf_d && (st_ovf_q != 16'hFFFF))      st_ovf_q  <= st_ovf_q + 16'd1;
            else                                      st_ovf_q  <= st_ovf_q;
            if (unf_d && (st_unf_q != 16'hFFFF))      st_unf_q  <= st_unf_q + 16'd1;
            else                                      st_unf_q  <= st_unf_q;
        end
    end

    assign stat_push = st_push_q;
    assign stat_pop  = st_pop_q;
    assign stat_ovf  = st_ovf_q;
    assign stat_unf  = st_unf_q;
`endif

endmodule
